// File: rtl/booth_mul_seq_if.sv
// Handshake bundle for booth_mul_seq: operand channel in, product channel out.
// master drives operands and out_ready; slave is the multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     P;
    logic                   busy;

    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, P, busy
    );

    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, P, busy
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock.
// It has signed/unsigned mode per operation and holds the product until the consumer takes it.
module booth_mul_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    booth_mul_seq_if.slave bus
);
    localparam int EW = WIDTH + 2;
    localparam int AW = 2*WIDTH + 4;
    localparam int N  = (WIDTH + 2) / 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg;
    logic [AW-1:0]        acc_reg;
    logic [AW-1:0]        mcand_reg;
    logic [EW-1:0]        mplier_reg;
    logic                 prev_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   p_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic                 busy_reg;

    logic [AW-1:0]        a_ext;
    logic [EW-1:0]        b_ext;
    logic [2:0]           triplet;
    logic                 mag1;
    logic                 mag2;
    logic                 neg;
    logic [AW-1:0]        addend_raw;
    logic [AW-1:0]        addend;
    logic [AW-1:0]        acc_next;

    // The multiplicand goes to accumulator width so the shifted partial products stay exact.
    assign a_ext = {{(AW-WIDTH){bus.signed_mode & bus.A[WIDTH-1]}}, bus.A};
    assign b_ext = {{(EW-WIDTH){bus.signed_mode & bus.B[WIDTH-1]}}, bus.B};

    assign triplet = {mplier_reg[1:0], prev_reg};

    always_comb begin
        mag1 = 1'b0;
        mag2 = 1'b0;
        neg  = 1'b0;
        case (triplet)
            3'b001, 3'b010: mag1 = 1'b1;
            3'b011:         mag2 = 1'b1;
            3'b100:         begin mag2 = 1'b1; neg = 1'b1; end
            3'b101, 3'b110: begin mag1 = 1'b1; neg = 1'b1; end
            default:        ;
        endcase
    end

    // Negation is ones' complement here, with the +1 entering as the adder carry-in.
    assign addend_raw = mag2 ? {mcand_reg[AW-2:0], 1'b0} :
                        mag1 ? mcand_reg : '0;
    assign addend     = neg ? ~addend_raw : addend_raw;
    assign acc_next   = acc_reg + addend + {{(AW-1){1'b0}}, neg};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prev_reg      <= 1'b0;
            cnt_reg       <= '0;
            p_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg    <= CALC;
                        acc_reg      <= '0;
                        mcand_reg    <= a_ext;
                        mplier_reg   <= b_ext;
                        prev_reg     <= 1'b0;
                        cnt_reg      <= CNT_W'(N);
                        p_reg        <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                CALC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[AW-3:0], 2'b00};
                    mplier_reg <= {2'b00, mplier_reg[EW-1:2]};
                    prev_reg   <= mplier_reg[1];
                    cnt_reg    <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg     <= DONE;
                        p_reg         <= acc_next[2*WIDTH-1:0];
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.P         = p_reg;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WIDTH 8, 16 and 32.
// One checked line is printed for each failure, and a summary line is printed at the end.
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mul_seq_if #(.WIDTH(8))  if8  ();
    booth_mul_seq_if #(.WIDTH(16)) if16 ();
    booth_mul_seq_if #(.WIDTH(32)) if32 ();

    booth_mul_seq #(.WIDTH(8))  dut8  (.sys_clk(clk), .sys_rst(rst), .bus(if8.slave));
    booth_mul_seq #(.WIDTH(16)) dut16 (.sys_clk(clk), .sys_rst(rst), .bus(if16.slave));
    booth_mul_seq #(.WIDTH(32)) dut32 (.sys_clk(clk), .sys_rst(rst), .bus(if32.slave));

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [63:0] p;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic sm);
        case (w)
            8:  begin if8.in_valid  = v; if8.A  = a[7:0];  if8.B  = b[7:0];  if8.signed_mode  = sm; end
            16: begin if16.in_valid = v; if16.A = a[15:0]; if16.B = b[15:0]; if16.signed_mode = sm; end
            default: begin if32.in_valid = v; if32.A = a; if32.B = b; if32.signed_mode = sm; end
        endcase
    endtask

    task automatic set_or(input int w, input logic v);
        case (w)
            8:       if8.out_ready  = v;
            16:      if16.out_ready = v;
            default: if32.out_ready = v;
        endcase
    endtask

    function automatic logic get_ov(input int w);
        case (w)
            8:       return if8.out_valid;
            16:      return if16.out_valid;
            default: return if32.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int w);
        case (w)
            8:       return if8.in_ready;
            16:      return if16.in_ready;
            default: return if32.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:       return if8.busy;
            16:      return if16.busy;
            default: return if32.busy;
        endcase
    endfunction

    function automatic logic [63:0] get_p(input int w);
        case (w)
            8:       return 64'(if8.P);
            16:      return 64'(if16.P);
            default: return 64'(if32.P);
        endcase
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference product: plain * on operands extended to 64 bits, truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sm);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        pmask;
        pmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        if (sm) begin
            sa = $signed(64'(a) << (64-w)) >>> (64-w);
            sb = $signed(64'(b) << (64-w)) >>> (64-w);
            return 64'(sa * sb) & pmask;
        end
        return ((64'(a) & wmask(w)) * (64'(b) & wmask(w))) & pmask;
    endfunction

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input int stall,
                          output logic [63:0] p, output int lat);
        set_in(w, 1'b1, a, b, sm);
        tick();
        set_in(w, 1'b0, a, b, sm);
        lat = 0;
        while (!get_ov(w) && lat < 40) begin
            tick();
            lat++;
        end
        p = get_p(w);
        repeat (stall) tick();
        set_or(w, 1'b1);
        tick();
        set_or(w, 1'b0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [63:0] p;
        logic [63:0] exp_p;
        int          lat;
        int          n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsm;

        rst = 1'b1;
        for (int w = 8; w <= 32; w = w * 2) begin
            set_in(w, 1'b0, 32'd0, 32'd0, 1'b0);
            set_or(w, 1'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int w = 8; w <= 32; w = w * 2) begin
            check($sformatf("reset_in_ready_w%0d", w), 64'(get_ir(w)), 64'd1);
            check($sformatf("reset_out_valid_w%0d", w), 64'(get_ov(w)), 64'd0);
            check($sformatf("reset_busy_w%0d", w), 64'(get_busy(w)), 64'd0);
            check($sformatf("reset_p_w%0d", w), get_p(w), 64'd0);
        end

        // Corner vectors
        vecs.push_back('{32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
        vecs.push_back('{32, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
        vecs.push_back('{32, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000});
        vecs.push_back('{32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{32, 32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000});
        vecs.push_back('{32, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 64'h0});
        vecs.push_back('{8,  32'h80, 32'h80, 1'b1, 64'h4000});
        vecs.push_back('{8,  32'hFF, 32'hFF, 1'b0, 64'hFE01});
        vecs.push_back('{8,  32'hFF, 32'hFF, 1'b1, 64'h0001});
        vecs.push_back('{8,  32'h7F, 32'h80, 1'b1, 64'hC080});
        vecs.push_back('{16, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000});
        vecs.push_back('{16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001});
        vecs.push_back('{16, 32'hFFFF, 32'h0003, 1'b1, 64'hFFFF_FFFD});

        foreach (vecs[i]) begin
            check($sformatf("corner%0d_in_ready", i), 64'(get_ir(vecs[i].w)), 64'd1);
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sm, i % 3, p, lat);
            check($sformatf("corner%0d_p", i), p, vecs[i].p);
            check($sformatf("corner%0d_latency", i), 64'(lat), 64'((vecs[i].w + 2) / 2));
        end

        // Backpressure with ignored in_valid pulses during CALC and DONE
        set_in(32, 1'b1, 32'h0001_0000, 32'h0003_0000, 1'b0);
        tick();
        check("bp_busy", 64'(get_busy(32)), 64'd1);
        check("bp_in_ready_calc", 64'(get_ir(32)), 64'd0);
        lat = 0;
        while (!get_ov(32) && lat < 40) begin
            set_in(32, lat[0], $urandom, $urandom, 1'b1);
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd17);
        for (int i = 0; i < 10; i++) begin
            set_in(32, ~i[0], $urandom, $urandom, i[1]);
            tick();
            check($sformatf("bp_p_%0d", i), get_p(32), 64'h0000_0003_0000_0000);
            check($sformatf("bp_out_valid_%0d", i), 64'(get_ov(32)), 64'd1);
            check($sformatf("bp_in_ready_%0d", i), 64'(get_ir(32)), 64'd0);
        end
        set_in(32, 1'b0, 32'd0, 32'd0, 1'b0);
        set_or(32, 1'b1);
        tick();
        set_or(32, 1'b0);
        check("bp_release_in_ready", 64'(get_ir(32)), 64'd1);
        check("bp_release_out_valid", 64'(get_ov(32)), 64'd0);
        check("bp_release_busy", 64'(get_busy(32)), 64'd0);

        // Reset in the middle of CALC
        set_in(32, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        tick();
        set_in(32, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(get_ov(32)), 64'd0);
        check("rst_p", get_p(32), 64'd0);
        check("rst_in_ready", 64'(get_ir(32)), 64'd1);
        check("rst_busy", 64'(get_busy(32)), 64'd0);
        repeat (20) begin
            tick();
            check("rst_no_out_valid", 64'(get_ov(32)), 64'd0);
        end
        run_op(32, 32'd3, 32'd5, 1'b0, 0, p, lat);
        check("rst_then_3x5", p, 64'd15);

        // Random regression at each width
        for (int w = 8; w <= 32; w = w * 2) begin
            n = (w == 32) ? 2000 : 200;
            for (int i = 0; i < n; i++) begin
                ra  = $urandom & wmask(w);
                rb  = $urandom & wmask(w);
                rsm = 1'($urandom_range(0, 1));
                exp_p = model(w, ra, rb, rsm);
                run_op(w, ra, rb, rsm, $urandom_range(0, 3), p, lat);
                check($sformatf("rand_w%0d_%0d", w, i), p, exp_p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
